// File: rtl/axi_pkg.sv
// Shared AXI write-response types for the B-channel reorder buffer.
// Response encoding, buffer entry layout and default bus widths.
package axi_pkg;

    localparam int AXI_ID_W   = 2;
    localparam int AXI_RESP_W = 2;

    typedef enum logic [AXI_RESP_W-1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef struct packed {
        logic                used;
        logic                done;
        logic [AXI_ID_W-1:0] id;
        resp_e               resp;
    } rob_entry_t;

    function automatic logic is_err_resp(input resp_e r);
        return (r == SLVERR) || (r == DECERR);
    endfunction

endpackage

// File: rtl/axi_bresp_reorder_buf_if.sv
// Allocation, AXI B and in-order completion channels of the reorder buffer.
// master drives requests and responses; slave is the buffer itself.
interface axi_bresp_reorder_buf_if
    import axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int RESP_W = AXI_RESP_W
) ();

    logic              alloc_valid;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [RESP_W-1:0] bresp;

    logic              out_valid;
    logic              out_ready;
    logic [ID_W-1:0]   out_id;
    logic [RESP_W-1:0] out_resp;

    modport master (
        output alloc_valid, alloc_id,
        output bvalid, bid, bresp,
        output out_ready,
        input  alloc_ready, bready,
        input  out_valid, out_id, out_resp
    );

    modport slave (
        input  alloc_valid, alloc_id,
        input  bvalid, bid, bresp,
        input  out_ready,
        output alloc_ready, bready,
        output out_valid, out_id, out_resp
    );

endinterface

// File: rtl/axi_bresp_reorder_buf_oldest_match_sel.sv
// Priority finder over DEPTH match bits, oldest first starting at head.
// Returns whether any bit is set and the absolute index of the oldest.
module oldest_match_sel #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         match,
    input  logic [$clog2(DEPTH)-1:0] head,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] index
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] pos;

    // Scan youngest to oldest so the oldest hit is the last one written.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            pos = head + AW'(k);
            if (match[pos]) begin
                hit   = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/axi_bresp_reorder_buf.sv
// In-order release buffer for out-of-order AXI B responses.
// Define BRESP_ERR_CNT_EN to build the saturating error-response counter.
module axi_bresp_reorder_buf
    import axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int DEPTH  = 8,
    parameter int RESP_W = AXI_RESP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_bresp_reorder_buf_if.slave   bus,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_unexpected,
    output logic [15:0]              err_cnt
);

    localparam int AW = $clog2(DEPTH);

    rob_entry_t     ent [DEPTH];
    logic [AW:0]    head;
    logic [AW:0]    tail;
    logic [AW-1:0]  head_idx;
    logic [AW-1:0]  tail_idx;
    logic [AW-1:0]  hit_idx;
    logic [DEPTH-1:0] match;
    logic           full;
    logic           hit;
    logic           alloc_fire;
    logic           b_fire;
    logic           pop;
    logic           bready_q;
    logic           err_q;

    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];
    assign full     = (head[AW] != tail[AW]) && (head_idx == tail_idx);

    assign bus.alloc_ready = rst_n && !full;
    assign bus.bready      = bready_q;
    assign bus.out_valid   = rst_n && ent[head_idx].used
                             && ent[head_idx].done;
    assign bus.out_id      = ID_W'(ent[head_idx].id);
    assign bus.out_resp    = RESP_W'(ent[head_idx].resp);

    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
    assign b_fire     = bus.bvalid && bready_q;
    assign pop        = bus.out_valid && bus.out_ready;

    assign outstanding    = rst_n ? (tail - head) : '0;
    assign err_unexpected = err_q;

    // Registered state only, so a slot allocated this cycle cannot match.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = ent[i].used && !ent[i].done
                       && (ent[i].id == AXI_ID_W'(bus.bid));
        end
    end

    oldest_match_sel #(
        .DEPTH (DEPTH)
    ) u_sel (
        .match (match),
        .head  (head_idx),
        .hit   (hit),
        .index (hit_idx)
    );

    // Alloc hits a free slot, match hits a pending one and pop a done
    // one, so the three writes never address the same entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            bready_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].used <= 1'b0;
                ent[i].done <= 1'b0;
            end
        end else begin
            bready_q <= 1'b1;
            err_q    <= b_fire && !hit;
            if (b_fire && hit) begin
                ent[hit_idx].done <= 1'b1;
                ent[hit_idx].resp <= resp_e'(AXI_RESP_W'(bus.bresp));
            end
            if (alloc_fire) begin
                ent[tail_idx] <= '{
                    used: 1'b1,
                    done: 1'b0,
                    id:   AXI_ID_W'(bus.alloc_id),
                    resp: OKAY
                };
                tail <= tail + 1'b1;
            end
            if (pop) begin
                ent[head_idx].used <= 1'b0;
                ent[head_idx].done <= 1'b0;
                head <= head + 1'b1;
            end
        end
    end

`ifdef BRESP_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (pop && is_err_resp(ent[head_idx].resp)
                     && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_bresp_reorder_buf.sv
// Self-checking bench for axi_bresp_reorder_buf: directed scenarios plus
// randomized traffic against a queue-based in-order completion model.
module tb_axi_bresp_reorder_buf;
    import axi_pkg::*;

    localparam int DEPTH = 8;
`ifdef BRESP_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  outstanding;
    logic        err_unexpected;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    axi_bresp_reorder_buf_if #(.ID_W(2), .RESP_W(2)) bus ();

    axi_bresp_reorder_buf #(
        .ID_W   (2),
        .DEPTH  (DEPTH),
        .RESP_W (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected),
        .err_cnt        (err_cnt)
    );

    typedef struct {
        logic [1:0] id;
        bit         done;
        logic [1:0] resp;
    } ment_t;

    ment_t q[$];
    bit    m_bready;
    bit    m_err;
    int    m_errcnt;
    int    n_tests;
    int    n_fail;

    function automatic bit m_valid();
        return (q.size() > 0) && q[0].done;
    endfunction

    // One clock: drive at negedge, update model at posedge, return at negedge.
    task automatic cycle(input bit av, input logic [1:0] aid,
                         input bit bv, input logic [1:0] b_id,
                         input logic [1:0] br, input bit ordy);
        int hit_i;
        bit do_pop;
        bit can_alloc;
        bus.alloc_valid = av;
        bus.alloc_id    = aid;
        bus.bvalid      = bv;
        bus.bid         = b_id;
        bus.bresp       = br;
        bus.out_ready   = ordy;
        hit_i = -1;
        if (bv && m_bready) begin
            foreach (q[i]) begin
                if (hit_i < 0 && !q[i].done && q[i].id == b_id) hit_i = i;
            end
        end
        do_pop    = m_valid() && ordy;
        can_alloc = q.size() < DEPTH;
        @(posedge clk);
        if (rst_n) begin
            m_err = bv && m_bready && (hit_i < 0);
            if (hit_i >= 0) begin
                q[hit_i].done = 1'b1;
                q[hit_i].resp = br;
            end
            if (do_pop) begin
                if (q[0].resp >= 2 && m_errcnt < 65535) m_errcnt++;
                void'(q.pop_front());
            end
            if (av && can_alloc) q.push_back('{id: aid, done: 1'b0, resp: 2'd0});
            m_bready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    // Leaves rst_n low at a negedge after two reset edges.
    task automatic do_reset(input bit inflight_b);
        rst_n           = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_id    = 2'd0;
        bus.bvalid      = inflight_b;
        bus.bid         = 2'd1;
        bus.bresp       = 2'd0;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        q.delete();
        m_bready = 1'b0;
        m_err    = 1'b0;
        m_errcnt = 0;
    endtask

    task automatic drain();
        int pend;
        for (int n = 0; n < 100 && q.size() > 0; n++) begin
            pend = -1;
            foreach (q[i]) if (pend < 0 && !q[i].done) pend = i;
            if (pend >= 0) cycle(1'b0, 2'd0, 1'b1, q[pend].id, 2'd0, 1'b1);
            else cycle(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
        end
        n_tests++;
        if (outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL drain_outstanding got=%0d want=0", outstanding);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_tests++;
        if (bus.alloc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_alloc_ready got=%0b want=0", bus.alloc_ready);
        end
        n_tests++;
        if (bus.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_bready got=%0b want=0", bus.bready);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_state got=%0b/%0d want=0/0",
                     bus.out_valid, outstanding);
        end
        n_tests++;
        if (err_cnt !== 16'd0 || err_unexpected !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err got=%0d/%0b want=0/0",
                     err_cnt, err_unexpected);
        end
        rst_n = 1'b1;
        idle();
        n_tests++;
        if (bus.bready !== 1'b1 || bus.alloc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_ready got=%0b/%0b want=1/1",
                     bus.bready, bus.alloc_ready);
        end
    endtask

    task automatic test_reorder();
        for (int k = 0; k < 3; k++) cycle(1'b1, 2'(k), 1'b0, 2'd0, 2'd0, 1'b0);
        n_tests++;
        if (outstanding !== 4'd3) begin
            n_fail++;
            $display("FAIL reorder_outstanding got=%0d want=3", outstanding);
        end
        cycle(1'b0, 2'd0, 1'b1, 2'd2, OKAY, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd1, OKAY, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reorder_early_valid got=%0b want=0", bus.out_valid);
        end
        cycle(1'b0, 2'd0, 1'b1, 2'd0, OKAY, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_id !== 2'(k)) begin
                n_fail++;
                $display("FAIL reorder_pop%0d got=%0b/%0d want=1/%0d",
                         k, bus.out_valid, bus.out_id, k);
            end
            cycle(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
        end
        n_tests++;
        if (outstanding !== 4'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reorder_empty got=%0d/%0b want=0/0",
                     outstanding, bus.out_valid);
        end
    endtask

    task automatic test_same_id();
        cycle(1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd1, SLVERR, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_resp !== 2'd2) begin
            n_fail++;
            $display("FAIL same_id_first got=%0b/%0d want=1/2",
                     bus.out_valid, bus.out_resp);
        end
        cycle(1'b0, 2'd0, 1'b1, 2'd1, OKAY, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1
            || bus.out_resp !== 2'd0) begin
            n_fail++;
            $display("FAIL same_id_second got=%0b/%0d/%0d want=1/1/0",
                     bus.out_valid, bus.out_id, bus.out_resp);
        end
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
        n_tests++;
        if (outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL same_id_empty got=%0d want=0", outstanding);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 2'(k % 4), 1'b0, 2'd0, 2'd0, 1'b0);
        n_tests++;
        if (bus.alloc_ready !== 1'b0 || outstanding !== 4'd8) begin
            n_fail++;
            $display("FAIL full_state got=%0b/%0d want=0/8",
                     bus.alloc_ready, outstanding);
        end
        cycle(1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0);
        n_tests++;
        if (outstanding !== 4'd8) begin
            n_fail++;
            $display("FAIL full_ignore got=%0d want=8", outstanding);
        end
        cycle(1'b0, 2'd0, 1'b1, 2'd0, OKAY, 1'b0);
        cycle(1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1);
        n_tests++;
        if (outstanding !== 4'd7 || bus.alloc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop got=%0d/%0b want=7/1",
                     outstanding, bus.alloc_ready);
        end
        cycle(1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0);
        n_tests++;
        if (outstanding !== 4'd8) begin
            n_fail++;
            $display("FAIL full_refill got=%0d want=8", outstanding);
        end
        drain();
    endtask

    task automatic test_unexpected();
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd3, OKAY, 1'b0);
        n_tests++;
        if (err_unexpected !== 1'b1 || outstanding !== 4'd1
            || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_pulse got=%0b/%0d/%0b want=1/1/0",
                     err_unexpected, outstanding, bus.out_valid);
        end
        idle();
        n_tests++;
        if (err_unexpected !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_one_cycle got=%0b want=0", err_unexpected);
        end
        cycle(1'b0, 2'd0, 1'b1, 2'd0, EXOKAY, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_resp !== 2'd1) begin
            n_fail++;
            $display("FAIL unexp_intact got=%0b/%0d want=1/1",
                     bus.out_valid, bus.out_resp);
        end
        drain();
    endtask

    task automatic test_random();
        int         pick;
        bit         av, bv, ordy;
        logic [1:0] b_id;
        for (int n = 0; n < 600; n++) begin
            av   = ($urandom_range(0, 9) < 6);
            bv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) < 4);
            b_id = 2'($urandom_range(0, 3));
            if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
                pick = $urandom_range(0, q.size() - 1);
                b_id = q[pick].id;
            end
            cycle(av, 2'($urandom_range(0, 3)), bv, b_id,
                  2'($urandom_range(0, 3)), ordy);
            n_tests++;
            if (bus.out_valid !== m_valid() || outstanding !== 4'(q.size())
                || bus.alloc_ready !== (q.size() < DEPTH)
                || err_unexpected !== m_err) begin
                n_fail++;
                $display("FAIL rnd_state@%0d got=%0b/%0d/%0b/%0b want=%0b/%0d/%0b/%0b",
                         n, bus.out_valid, outstanding, bus.alloc_ready,
                         err_unexpected, m_valid(), q.size(),
                         q.size() < DEPTH, m_err);
            end
            if (m_valid()) begin
                n_tests++;
                if (bus.out_id !== q[0].id || bus.out_resp !== q[0].resp) begin
                    n_fail++;
                    $display("FAIL rnd_head@%0d got=%0d/%0d want=%0d/%0d",
                             n, bus.out_id, bus.out_resp, q[0].id, q[0].resp);
                end
            end
            n_tests++;
            if (err_cnt !== (CNT_EN ? 16'(m_errcnt) : 16'd0)) begin
                n_fail++;
                $display("FAIL rnd_err_cnt@%0d got=%0d want=%0d",
                         n, err_cnt, CNT_EN ? m_errcnt : 0);
            end
        end
        drain();
    endtask

    task automatic test_hold_and_reset();
        cycle(1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd2, DECERR, 1'b0);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2
                || bus.out_resp !== 2'd3) begin
                n_fail++;
                $display("FAIL hold@%0d got=%0b/%0d/%0d want=1/2/3",
                         k, bus.out_valid, bus.out_id, bus.out_resp);
            end
            cycle(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        end
        cycle(1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        do_reset(1'b1);
        n_tests++;
        if (outstanding !== 4'd0 || bus.out_valid !== 1'b0
            || bus.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst got=%0d/%0b/%0b want=0/0/0",
                     outstanding, bus.out_valid, bus.bready);
        end
        rst_n = 1'b1;
        idle();
        n_tests++;
        if (bus.bready !== 1'b1 || outstanding !== 4'd0
            || err_unexpected !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after got=%0b/%0d/%0b want=1/0/0",
                     bus.bready, outstanding, err_unexpected);
        end
    endtask

    task automatic test_err_cnt();
        do_reset(1'b0);
        rst_n = 1'b1;
        idle();
        for (int k = 0; k < 3; k++) cycle(1'b1, 2'(k), 1'b0, 2'd0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd0, OKAY, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd1, SLVERR, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd2, DECERR, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
        n_tests++;
        if (err_cnt !== (CNT_EN ? 16'd2 : 16'd0) || outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL err_cnt got=%0d/%0d want=%0d/0",
                     err_cnt, outstanding, CNT_EN ? 2 : 0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_reorder();
        test_same_id();
        test_full();
        test_unexpected();
        test_random();
        test_hold_and_reset();
        test_err_cnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
